// File: rtl/anybit_enc_if.sv
// Producer/consumer bundle for anybit_enc: vector load side plus index handshake.
// count_out exists only when ANYBIT_ENC_COUNT_EN is defined.
interface anybit_enc_if #(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
);
  logic                enable;
  logic                load;
  logic [IN_SIZE-1:0]  vec_in;
  logic                idx_ready;
  logic                busy;
  logic [OUT_SIZE-1:0] idx_out;
  logic                idx_valid;
  logic                done;
  logic                none;
`ifdef ANYBIT_ENC_COUNT_EN
  logic [OUT_SIZE:0]   count_out;
`endif

`ifdef ANYBIT_ENC_COUNT_EN
  modport master (
    output enable, load, vec_in, idx_ready,
    input  busy, idx_out, idx_valid, done, none, count_out
  );
  modport slave (
    input  enable, load, vec_in, idx_ready,
    output busy, idx_out, idx_valid, done, none, count_out
  );
`else
  modport master (
    output enable, load, vec_in, idx_ready,
    input  busy, idx_out, idx_valid, done, none
  );
  modport slave (
    input  enable, load, vec_in, idx_ready,
    output busy, idx_out, idx_valid, done, none
  );
`endif
endinterface

// File: rtl/anybit_enc.sv
// Multi-hot to index encoder: captures a vector, emits set-bit indices lowest first.
// Optional popcount output is enabled by defining ANYBIT_ENC_COUNT_EN.
module anybit_enc #(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic        clock,
  input  logic        reset_n,
  anybit_enc_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              r_state;
  logic [IN_SIZE-1:0]  r_pend;
  logic [OUT_SIZE-1:0] r_idx;
  logic                r_valid;
  logic                r_done;
  logic                r_none;
  logic [IN_SIZE-1:0]  w_rest;
`ifdef ANYBIT_ENC_COUNT_EN
  logic [OUT_SIZE:0]   r_count;
`endif

  function automatic logic [OUT_SIZE-1:0] lowest_set(input logic [IN_SIZE-1:0] v);
    logic [OUT_SIZE-1:0] idx;
    logic                found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      if (v[i] && !found) begin
        idx   = OUT_SIZE'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

`ifdef ANYBIT_ENC_COUNT_EN
  function automatic logic [OUT_SIZE:0] pop_count(input logic [IN_SIZE-1:0] v);
    logic [OUT_SIZE:0] n;
    n = '0;
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      n += (OUT_SIZE+1)'(v[i]);
    end
    return n;
  endfunction
`endif

  // Clearing the lowest set bit of pend is exactly retiring the index on idx_out.
  assign w_rest = r_pend & (r_pend - IN_SIZE'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_none  <= 1'b0;
`ifdef ANYBIT_ENC_COUNT_EN
      r_count <= '0;
`endif
    end else begin
      // Completion pulses always self-clear, even while enable is low.
      r_done <= 1'b0;
      r_none <= 1'b0;
      if (bus.enable) begin
        case (r_state)
          IDLE: begin
            if (bus.load) begin
              r_pend <= bus.vec_in;
`ifdef ANYBIT_ENC_COUNT_EN
              r_count <= pop_count(bus.vec_in);
`endif
              if (|bus.vec_in) begin
                r_state <= EMIT;
                r_idx   <= lowest_set(bus.vec_in);
                r_valid <= 1'b1;
              end else begin
                r_done <= 1'b1;
                r_none <= 1'b1;
              end
            end
          end
          EMIT: begin
            if (r_valid && bus.idx_ready) begin
              r_pend <= w_rest;
              if (w_rest == '0) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx <= lowest_set(w_rest);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = (r_state == EMIT);
  assign bus.idx_out   = r_idx;
  assign bus.idx_valid = r_valid;
  assign bus.done      = r_done;
  assign bus.none      = r_none;
`ifdef ANYBIT_ENC_COUNT_EN
  assign bus.count_out = r_count;
`endif

endmodule

// File: tb/tb_anybit_enc.sv
// Scoreboard bench for anybit_enc (IN_SIZE=16, OUT_SIZE=4); count_out checked when ANYBIT_ENC_COUNT_EN is defined.
module tb_anybit_enc;
  localparam int END  = -1;
  localparam int ZERO = -2;

  logic clock;
  logic reset_n;
  int   n_pass;
  int   n_total;
  int   sb[$];

  anybit_enc_if #(.OUT_SIZE(4), .IN_SIZE(16)) bus_if ();

  anybit_enc #(.OUT_SIZE(4), .IN_SIZE(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_cycle(input string name);
    int code;
    if (bus_if.idx_valid) begin
      n_total++;
      if (sb.size() == 0 || int'(bus_if.idx_out) !== sb[0])
        $display("FAIL %s_idx: idx_out=%0d, required %0d", name, bus_if.idx_out,
                 (sb.size() == 0) ? 99 : sb[0]);
      else n_pass++;
      if (bus_if.idx_ready && bus_if.enable && sb.size() != 0) void'(sb.pop_front());
    end
    if (bus_if.done) begin
      code = bus_if.none ? ZERO : END;
      n_total++;
      if (sb.size() == 0 || code !== sb[0] || bus_if.busy !== 1'b0 || bus_if.idx_valid !== 1'b0)
        $display("FAIL %s_done: code=%0d busy=%b valid=%b, required code=%0d busy=0 valid=0",
                 name, code, bus_if.busy, bus_if.idx_valid, (sb.size() == 0) ? 99 : sb[0]);
      else n_pass++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  task automatic drain_timeout(input string name);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: %0d expected events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    bus_if.enable    = 1'b1;
    bus_if.load      = 1'b0;
    bus_if.vec_in    = '0;
    bus_if.idx_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if ({bus_if.busy, bus_if.idx_valid, bus_if.done, bus_if.none, bus_if.idx_out} !== 8'h00)
      $display("FAIL reset_outputs: busy=%b valid=%b done=%b none=%b idx=%0d, required all 0",
               bus_if.busy, bus_if.idx_valid, bus_if.done, bus_if.none, bus_if.idx_out);
    else n_pass++;
`ifdef ANYBIT_ENC_COUNT_EN
    n_total++;
    if (bus_if.count_out !== 5'd0) $display("FAIL reset_count: count_out=%0d, required 0", bus_if.count_out);
    else n_pass++;
`endif
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    sb.push_back(8);
    sb.push_back(END);
    bus_if.vec_in    = 16'h0100;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.load = 1'b0;
      if (c == 0) begin
        n_total++;
        if (bus_if.idx_valid !== 1'b1 || bus_if.busy !== 1'b1)
          $display("FAIL single_latency: valid=%b busy=%b, required 1 1", bus_if.idx_valid, bus_if.busy);
        else n_pass++;
      end
      check_cycle("single");
    end
    drain_timeout("single");
  endtask

  task automatic test_multi();
    foreach (sb[i]) ;
    sb.push_back(0); sb.push_back(5); sb.push_back(10); sb.push_back(15); sb.push_back(END);
    @(negedge clock);
    bus_if.vec_in    = 16'h8421;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    for (int c = 0; c < 12 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.load = 1'b0;
      check_cycle("multi");
    end
    drain_timeout("multi");
`ifdef ANYBIT_ENC_COUNT_EN
    n_total++;
    if (bus_if.count_out !== 5'd4) $display("FAIL multi_count: count_out=%0d, required 4", bus_if.count_out);
    else n_pass++;
`endif
  endtask

  task automatic test_stall();
    sb.push_back(1); sb.push_back(2); sb.push_back(END);
    @(negedge clock);
    bus_if.vec_in    = 16'h0006;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b0;
    for (int c = 0; c < 12 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.load      = 1'b0;
      bus_if.idx_ready = (c >= 3);
      check_cycle("stall");
    end
    drain_timeout("stall");
  endtask

  task automatic test_zero();
    sb.push_back(ZERO);
    @(negedge clock);
    bus_if.vec_in    = 16'h0000;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    for (int c = 0; c < 6 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.load = 1'b0;
      if (c == 0) begin
        n_total++;
        if (bus_if.done !== 1'b1 || bus_if.none !== 1'b1)
          $display("FAIL zero_latency: done=%b none=%b, required 1 1", bus_if.done, bus_if.none);
        else n_pass++;
      end
      check_cycle("zero");
    end
    drain_timeout("zero");
    @(negedge clock);
    n_total++;
    if (bus_if.done !== 1'b0 || bus_if.none !== 1'b0)
      $display("FAIL zero_pulse_width: done=%b none=%b, required 0 0", bus_if.done, bus_if.none);
    else n_pass++;
  endtask

  task automatic test_freeze();
    sb.push_back(4); sb.push_back(5); sb.push_back(6); sb.push_back(7); sb.push_back(END);
    @(negedge clock);
    bus_if.vec_in    = 16'h00F0;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    for (int c = 0; c < 15 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.enable = !(c == 2 || c == 3);
      bus_if.load   = (c == 1 || c == 2);
      bus_if.vec_in = (c == 0) ? 16'h00F0 : 16'hFFFF;
      check_cycle("freeze");
    end
    drain_timeout("freeze");
    bus_if.enable = 1'b1;
    bus_if.load   = 1'b0;
    @(negedge clock);
    n_total++;
    if (bus_if.busy !== 1'b0 || bus_if.idx_valid !== 1'b0)
      $display("FAIL freeze_idle: busy=%b valid=%b, required 0 0", bus_if.busy, bus_if.idx_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit reloaded;
    reloaded = 1'b0;
    sb.push_back(0); sb.push_back(1); sb.push_back(END); sb.push_back(10); sb.push_back(END);
    @(negedge clock);
    bus_if.vec_in    = 16'h0003;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    for (int c = 0; c < 15 && sb.size() != 0; c++) begin
      @(negedge clock);
      bus_if.load = 1'b0;
      if (bus_if.done && !reloaded) begin
        bus_if.vec_in = 16'h0400;
        bus_if.load   = 1'b1;
        reloaded      = 1'b1;
      end
      check_cycle("b2b");
    end
    drain_timeout("b2b");
    bus_if.load = 1'b0;
  endtask

  task automatic test_reset_mid_emit();
    @(negedge clock);
    bus_if.vec_in    = 16'h00F0;
    bus_if.load      = 1'b1;
    bus_if.idx_ready = 1'b1;
    @(negedge clock);
    bus_if.load = 1'b0;
    n_total++;
    if (bus_if.idx_valid !== 1'b1 || bus_if.idx_out !== 4'd4)
      $display("FAIL rst_first_idx: valid=%b idx=%0d, required 1 4", bus_if.idx_valid, bus_if.idx_out);
    else n_pass++;
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if ({bus_if.busy, bus_if.idx_valid, bus_if.done, bus_if.none, bus_if.idx_out} !== 8'h00)
      $display("FAIL rst_async: busy=%b valid=%b done=%b none=%b idx=%0d, required all 0",
               bus_if.busy, bus_if.idx_valid, bus_if.done, bus_if.none, bus_if.idx_out);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      n_total++;
      if (bus_if.busy !== 1'b0 || bus_if.idx_valid !== 1'b0 || bus_if.done !== 1'b0)
        $display("FAIL rst_after_release: busy=%b valid=%b done=%b, required 0 0 0",
                 bus_if.busy, bus_if.idx_valid, bus_if.done);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_zero();
    test_freeze();
    test_back_to_back();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/anybit_enc.md
ANYBIT_ENC -- requirements
Module: anybit_enc

Interface
REQ-001 SHALL have parameter OUT_SIZE, default 4, meaning index width in bits.
REQ-002 SHALL have parameter IN_SIZE, default 1<<OUT_SIZE, meaning input vector width.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  global enable; low freezes all state.
REQ-006 SHALL have port vec_in  input  IN_SIZE  one-hot or multi-hot vector to encode.
REQ-007 SHALL have port load  input  1  capture request for vec_in.
REQ-008 SHALL have port busy  output  1  high while captured bits remain to emit.
REQ-009 SHALL have port idx_out  output  OUT_SIZE  binary index of the current set bit.
REQ-010 SHALL have port idx_valid  output  1  idx_out valid.
REQ-011 SHALL have port idx_ready  input  1  consumer accepts idx_out.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of a vector.
REQ-013 SHALL have port none  output  1  one-cycle pulse, with done, when captured vector was all-zero.

Function
REQ-014 SHALL implement states IDLE and EMIT, held in a state register.
REQ-015 SHALL, in IDLE with enable=1 and load=1, capture vec_in into pending register pend.
REQ-016 SHALL move IDLE->EMIT on a capture of a nonzero vector; idx_valid=1 and idx_out=lowest set bit index in the next cycle (1-cycle latency).
REQ-017 SHALL, on capture of an all-zero vector, stay in IDLE and pulse done=1, none=1 in the next cycle; idx_valid stays 0.
REQ-018 SHALL complete a transfer only in a cycle where enable=1, idx_valid=1, idx_ready=1.
REQ-019 SHALL, on transfer, clear the emitted bit in pend and present the next-lowest set bit on the following cycle (one index per cycle when idx_ready held high).
REQ-020 SHALL hold idx_out and idx_valid stable while idx_valid=1 and no transfer occurs.
REQ-021 SHALL, on transfer of the last set bit, return to IDLE, drop idx_valid and busy, and pulse done=1 (none=0) in the next cycle.
REQ-022 SHALL ignore load while in EMIT; pend is not modified by vec_in.
REQ-023 SHALL, when enable=0, freeze state, pend and outputs; done/none pulses are not extended by enable=0 (they clear next cycle).
REQ-024 SHALL drive busy=1 exactly when state is EMIT.
REQ-025 SHALL emit indices in strictly ascending order; IN_SIZE-1 is the highest emittable index.
REQ-026 SHALL register all outputs (no combinational path from inputs to outputs).
REQ-027 SHALL accept a new load in the cycle done is high (back-to-back vectors, no dead cycle).

Reset
REQ-028 SHALL, while reset_n=0, force state=IDLE, pend=0, idx_out=0, idx_valid=0, busy=0, done=0, none=0, asynchronously.
REQ-029 SHALL abandon an in-progress vector on reset mid-EMIT with no done pulse.

Configuration
REQ-030 SHALL support macro ANYBIT_ENC_COUNT_EN.
REQ-031 SHALL, with ANYBIT_ENC_COUNT_EN defined, add output count_out, width OUT_SIZE+1, equal to the population count of the captured vector, registered on capture, held until next capture, reset to 0.
REQ-032 SHALL, without ANYBIT_ENC_COUNT_EN, omit count_out and its logic entirely; all other behaviour identical.

Verification (IN_SIZE=16, OUT_SIZE=4)
REQ-033 SHALL cover: load vec_in=16'h0100, idx_ready=1 -> next cycle idx_out=8, idx_valid=1; following cycle done=1, busy=0.
REQ-034 SHALL cover: load 16'h8421, idx_ready=1 -> idx_out 0,5,10,15 on four consecutive cycles, done after 15; count_out=4 if macro defined.
REQ-035 SHALL cover: load 16'h0006, idx_ready=0 for 3 cycles -> idx_out=1 held; ready=1 -> 2 then done.
REQ-036 SHALL cover: load 16'h0000 -> no idx_valid, done=1 and none=1 one cycle later.
REQ-037 SHALL cover: load 16'h00F0, enable=0 for 2 cycles mid-EMIT, load 16'hFFFF during EMIT -> sequence 4,5,6,7 unchanged, second load ignored.
REQ-038 SHALL cover: reset_n=0 asserted after index 4 of 16'h00F0 -> all outputs 0 immediately, IDLE after release, no done.
